// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, W+2 cycles per product.
// Signed operands are multiplied as magnitudes; the sign is applied in FIX.
module seq_multiplier #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] P_hi,
  output logic [W-1:0] P_lo
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t         state;
  logic [W-1:0]   mcand;
  logic [2*W:0]   acc;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;
  logic [W:0]     sum;
  logic [W:0]     hi;
  logic [2*W-1:0] prod;

  always_comb begin
    a_abs = (is_signed && A[W-1]) ? -A : A;
    b_abs = (is_signed && B[W-1]) ? -B : B;
    sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    hi    = acc[0] ? sum : acc[2*W:W];
    prod  = neg ? -acc[2*W-1:0] : acc[2*W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P_hi  <= '0;
      P_lo  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_abs;
            acc   <= {{(W+1){1'b0}}, b_abs};
            neg   <= is_signed & (A[W-1] ^ B[W-1]);
            cnt   <= CW'(W-1);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // The multiplier bits shift out of the low half as the product grows in.
          acc <= {1'b0, hi, acc[W-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          P_hi  <= prod[2*W-1:W];
          P_lo  <= prod[W-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
